// File: rtl/bus_arbiter_m2_split.sv
// ---------------------------------------------------------------------------
// bus_arbiter_m2_split
//
// Two-master bus arbiter with split-transaction support. Master 1 is the
// master port and master 2 is the bus-bridge master. A split-capable slave
// can park the current owner. The bus is then free for the other master.
// The parked owner resumes later, with priority, once the slave reports
// ready.
//
// Parameters
//   RR_MODE        0 = fixed priority (master 1 wins ties)
//                  1 = round-robin (a tie goes to the master not granted last)
//
// Ports
//   clk            system clock
//   rstn           synchronous active-low reset
//   m1_breq        bus request, master 1 (held through tenure and while parked)
//   m2_breq        bus request, master 2
//   m1_bgrant      bus grant, master 1 (registered)
//   m2_bgrant      bus grant, master 2 (registered)
//   m1_split       master 1 is parked by a split (registered)
//   m2_split       master 2 is parked by a split (registered)
//   s_split        one-cycle pulse from the slave: split the current owner
//   s_split_ready  level from the slave: the parked transaction may resume
//   split_grant    the resumed owner holds the bus (registered)
//   owner          0 = none, 1 = master 1, 2 = master 2; bus mux select
// ---------------------------------------------------------------------------
module bus_arbiter_m2_split #(
    parameter bit RR_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       m1_breq,
    input  logic       m2_breq,
    output logic       m1_bgrant,
    output logic       m2_bgrant,
    output logic       m1_split,
    output logic       m2_split,
    input  logic       s_split,
    input  logic       s_split_ready,
    output logic       split_grant,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } state_t;

    state_t     state;
    logic       pending;      // a parked transaction is waiting to resume
    logic [1:0] split_owner;  // 0 = none, 1 = master 1, 2 = master 2
    logic [1:0] last_grant;   // most recently granted master, for round-robin

    logic elig1;
    logic elig2;
    logic pick1;
    logic resume_breq;

    // A parked master keeps breq high but must not win normal arbitration.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        elig1       = m1_breq && !(pending && split_owner == 2'd1);
        elig2       = m2_breq && !(pending && split_owner == 2'd2);
        pick1       = elig1;
        if (elig1 && elig2) begin
            pick1 = RR_MODE ? (last_grant != 2'd1) : 1'b1;
        end
        resume_breq = (split_owner == 2'd1) ? m1_breq : m2_breq;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and covers every register, since
        // there is no memory array here that would need to stay unreset.
        if (!rstn) begin
            state       <= IDLE;
            pending     <= 1'b0;
            split_owner <= 2'd0;
            last_grant  <= 2'd2;
            m1_bgrant   <= 1'b0;
            m2_bgrant   <= 1'b0;
            m1_split    <= 1'b0;
            m2_split    <= 1'b0;
            split_grant <= 1'b0;
            owner       <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending && s_split_ready) begin
                        // Resume the parked owner. If it has dropped its
                        // request the split is abandoned and nobody is granted.
                        pending     <= 1'b0;
                        split_owner <= 2'd0;
                        m1_split    <= 1'b0;
                        m2_split    <= 1'b0;
                        if (resume_breq) begin
                            split_grant <= 1'b1;
                            owner       <= split_owner;
                            last_grant  <= split_owner;
                            if (split_owner == 2'd1) begin
                                state     <= GNT1;
                                m1_bgrant <= 1'b1;
                            end else begin
                                state     <= GNT2;
                                m2_bgrant <= 1'b1;
                            end
                        end
                    end else if (elig1 || elig2) begin
                        if (pick1) begin
                            state      <= GNT1;
                            m1_bgrant  <= 1'b1;
                            owner      <= 2'd1;
                            last_grant <= 2'd1;
                        end else begin
                            state      <= GNT2;
                            m2_bgrant  <= 1'b1;
                            owner      <= 2'd2;
                            last_grant <= 2'd2;
                        end
                    end
                end

                GNT1: begin
                    // A split outranks a simultaneous release; a second split
                    // while one is already pending is ignored.
                    if (s_split && !pending) begin
                        state       <= IDLE;
                        pending     <= 1'b1;
                        split_owner <= 2'd1;
                        m1_split    <= 1'b1;
                        m1_bgrant   <= 1'b0;
                        split_grant <= 1'b0;
                        owner       <= 2'd0;
                    end else if (!m1_breq) begin
                        state       <= IDLE;
                        m1_bgrant   <= 1'b0;
                        split_grant <= 1'b0;
                        owner       <= 2'd0;
                    end
                end

                GNT2: begin
                    if (s_split && !pending) begin
                        state       <= IDLE;
                        pending     <= 1'b1;
                        split_owner <= 2'd2;
                        m2_split    <= 1'b1;
                        m2_bgrant   <= 1'b0;
                        split_grant <= 1'b0;
                        owner       <= 2'd0;
                    end else if (!m2_breq) begin
                        state       <= IDLE;
                        m2_bgrant   <= 1'b0;
                        split_grant <= 1'b0;
                        owner       <= 2'd0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    m1_bgrant   <= 1'b0;
                    m2_bgrant   <= 1'b0;
                    split_grant <= 1'b0;
                    owner       <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_m2_split.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_m2_split
//
// Drives one round-robin and one fixed-priority instance with shared inputs.
// A behavioural model tracks, per instance, who owns the bus, who is parked
// and who was granted last. Outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_m2_split;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn, m1_breq, m2_breq, s_split, s_split_ready;

    logic       rr_g1, rr_g2, rr_s1, rr_s2, rr_sg;
    logic [1:0] rr_own;
    logic       fp_g1, fp_g2, fp_s1, fp_s2, fp_sg;
    logic [1:0] fp_own;

    bus_arbiter_m2_split #(.RR_MODE(1'b1)) dut_rr (
        .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
        .m1_bgrant(rr_g1), .m2_bgrant(rr_g2), .m1_split(rr_s1), .m2_split(rr_s2),
        .s_split(s_split), .s_split_ready(s_split_ready),
        .split_grant(rr_sg), .owner(rr_own)
    );

    bus_arbiter_m2_split #(.RR_MODE(1'b0)) dut_fp (
        .clk(clk), .rstn(rstn), .m1_breq(m1_breq), .m2_breq(m2_breq),
        .m1_bgrant(fp_g1), .m2_bgrant(fp_g2), .m1_split(fp_s1), .m2_split(fp_s2),
        .s_split(s_split), .s_split_ready(s_split_ready),
        .split_grant(fp_sg), .owner(fp_own)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model index 0 = fixed priority, 1 = round-robin.
    int m_cur[2];     // bus owner, 0 = nobody
    int m_parked[2];  // parked master, 0 = nobody
    int m_last[2];    // last master granted
    bit m_sg[2];      // current tenure is a resumed split

    task automatic model_step(input int k, input bit rr);
        bit b[3];
        bit e1, e2;
        int x;
        b[0] = 1'b0;
        b[1] = m1_breq;
        b[2] = m2_breq;
        if (!rstn) begin
            m_cur[k] = 0; m_parked[k] = 0; m_sg[k] = 0; m_last[k] = 2;
        end else if (m_cur[k] == 0) begin
            if (m_parked[k] != 0 && s_split_ready) begin
                x = m_parked[k];
                m_parked[k] = 0;
                if (b[x]) begin
                    m_cur[k] = x; m_sg[k] = 1; m_last[k] = x;
                end
            end else begin
                e1 = m1_breq && m_parked[k] != 1;
                e2 = m2_breq && m_parked[k] != 2;
                if (e1 && e2) x = rr ? 3 - m_last[k] : 1;
                else if (e1)  x = 1;
                else if (e2)  x = 2;
                else          x = 0;
                if (x != 0) begin
                    m_cur[k] = x; m_last[k] = x;
                end
            end
        end else begin
            x = m_cur[k];
            if (s_split && m_parked[k] == 0) begin
                m_parked[k] = x; m_cur[k] = 0; m_sg[k] = 0;
            end else if (!b[x]) begin
                m_cur[k] = 0; m_sg[k] = 0;
            end
        end
    endtask

    task automatic check_dut(input string p, input int k,
                             input logic g1, input logic g2, input logic s1,
                             input logic s2, input logic sg, input logic [1:0] own);
        check({p, "_m1_bgrant"},   8'(g1),  8'(m_cur[k] == 1));
        check({p, "_m2_bgrant"},   8'(g2),  8'(m_cur[k] == 2));
        check({p, "_m1_split"},    8'(s1),  8'(m_parked[k] == 1));
        check({p, "_m2_split"},    8'(s2),  8'(m_parked[k] == 2));
        check({p, "_split_grant"}, 8'(sg),  8'(m_sg[k]));
        check({p, "_owner"},       8'(own), 8'(m_cur[k]));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        @(negedge clk);
        check_dut("fp", 0, fp_g1, fp_g2, fp_s1, fp_s2, fp_sg, fp_own);
        check_dut("rr", 1, rr_g1, rr_g2, rr_s1, rr_s2, rr_sg, rr_own);
    endtask

    task automatic do_reset();
        rstn = 1'b0; m1_breq = 1'b0; m2_breq = 1'b0;
        s_split = 1'b0; s_split_ready = 1'b0;
        cycle();
        rstn = 1'b1;
    endtask

    // Both masters keep requesting; each drops breq for one cycle once it has
    // held the bus for 4 cycles. Stimulus follows model instance k. Every new
    // tenure is checked against the expected alternating/fixed pattern.
    task automatic run_tenures(input int k, input int ncyc);
        int ten1, ten2, idle_run, n_grants, prev, cur, exp_m;
        ten1 = 0; ten2 = 0; idle_run = 0; n_grants = 0; prev = 0;
        m1_breq = 1'b1; m2_breq = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            cycle();
            cur = (k == 1) ? int'(rr_own) : int'(fp_own);
            if (cur != 0 && prev == 0) begin
                exp_m = (k == 1) ? ((n_grants % 2 == 0) ? 1 : 2) : 1;
                check(k == 1 ? "rr_alt_owner" : "fp_fixed_owner", 8'(cur), 8'(exp_m));
                if (n_grants > 0) check("turnaround_idle", 8'(idle_run), 8'd1);
                n_grants++;
            end
            idle_run = (cur == 0) ? idle_run + 1 : 0;
            prev = cur;
            ten1 = (m_cur[k] == 1) ? ten1 + 1 : 0;
            ten2 = (m_cur[k] == 2) ? ten2 + 1 : 0;
            m1_breq = (ten1 < 4);
            m2_breq = (ten2 < 4);
        end
        check("tenures_seen", 8'(n_grants >= 4), 8'd1);
        m1_breq = 1'b0; m2_breq = 1'b0;
        cycle(); cycle();
    endtask

    initial begin
        // Reset, then a lone master 1 request.
        do_reset();
        cycle();
        check("rst_owner", 8'(rr_own), 8'd0);
        m1_breq = 1'b1;
        cycle();
        check("first_m1_bgrant", 8'(rr_g1), 8'd1);
        check("first_owner",     8'(rr_own), 8'd1);
        check("first_m2_bgrant", 8'(rr_g2), 8'd0);
        m1_breq = 1'b0;
        cycle(); cycle();

        // Alternation in round-robin, master 1 always wins in fixed priority.
        do_reset();
        run_tenures(1, 40);
        do_reset();
        run_tenures(0, 30);

        // Split of master 2, master 1 tenure, then resume of master 2.
        do_reset();
        m2_breq = 1'b1;
        cycle(); cycle(); cycle();
        s_split = 1'b1;
        cycle();
        s_split = 1'b0;
        check("split_m2_bgrant", 8'(rr_g2), 8'd0);
        check("split_m2_split",  8'(rr_s2), 8'd1);
        m1_breq = 1'b1;
        cycle();
        check("m1_during_split", 8'(rr_g1), 8'd1);
        s_split_ready = 1'b1;
        cycle(); cycle();
        check("ready_no_preempt", 8'(rr_own), 8'd1);
        m1_breq = 1'b0;
        cycle(); cycle();
        check("resume_m2_bgrant",   8'(rr_g2), 8'd1);
        check("resume_split_grant", 8'(rr_sg), 8'd1);
        check("resume_m2_split",    8'(rr_s2), 8'd0);
        m2_breq = 1'b0; s_split_ready = 1'b0;
        cycle(); cycle();

        // Resume outranks a fresh request in the same IDLE cycle.
        do_reset();
        m2_breq = 1'b1;
        cycle(); cycle();
        s_split = 1'b1;
        cycle();
        s_split = 1'b0; m1_breq = 1'b1; s_split_ready = 1'b1;
        cycle();
        check("prio_m2_bgrant", 8'(rr_g2), 8'd1);
        check("prio_m1_bgrant", 8'(rr_g1), 8'd0);
        m1_breq = 1'b0; m2_breq = 1'b0; s_split_ready = 1'b0;
        cycle(); cycle();

        // Split with simultaneous breq drop, second split ignored, then reset.
        do_reset();
        m1_breq = 1'b1;
        cycle(); cycle();
        s_split = 1'b1; m1_breq = 1'b0;
        cycle();
        s_split = 1'b0;
        check("drop_split_m1_split", 8'(rr_s1), 8'd1);
        m2_breq = 1'b1;
        cycle(); cycle();
        s_split = 1'b1;
        cycle();
        s_split = 1'b0;
        check("second_split_m2_keeps", 8'(rr_g2), 8'd1);
        check("second_split_m1_split", 8'(rr_s1), 8'd1);
        rstn = 1'b0;
        cycle();
        check("midrst_outputs",
              8'({rr_g1, rr_g2, rr_s1, rr_s2, rr_sg, rr_own}), 8'd0);
        rstn = 1'b1; m1_breq = 1'b1; m2_breq = 1'b1;
        cycle();
        check("postrst_tie_m1", 8'(rr_own), 8'd1);
        m1_breq = 1'b0; m2_breq = 1'b0;
        cycle(); cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rstn          = ($urandom_range(199) != 0);
            if ($urandom_range(5) == 0) m1_breq = ~m1_breq;
            if ($urandom_range(5) == 0) m2_breq = ~m2_breq;
            s_split       = ($urandom_range(7) == 0);
            s_split_ready = ($urandom_range(3) == 0);
            cycle();
            check("mutex_rr", 8'(rr_g1 & rr_g2), 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_m2_split.md
Name: bus_arbiter_m2_split

Overview:
Arbiter for the two-master serial system bus (master port 1, bus-bridge master 2). It grants bus ownership, tracks the current owner for the bus mux, and handles split transactions. On a split, the split-capable slave (the bus-bridge slave) parks the current owner, frees the bus for the other master, and later resumes the parked master with priority. It sits inside the bus block between the masters' breq/bgrant/split lines and the slave-side split/split_grant lines.

Parameters:
RR_MODE, 1, 0 = fixed priority (master 1 wins ties); 1 = round-robin (tie goes to the master not granted most recently).

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset
m1_breq  input  1  bus request, master 1; held high for the whole tenure, including while parked
m2_breq  input  1  bus request, master 2
m1_bgrant  output  1  bus grant, master 1
m2_bgrant  output  1  bus grant, master 2
m1_split  output  1  master 1 is parked by a split
m2_split  output  1  master 2 is parked by a split
s_split  input  1  one-cycle pulse from the split-capable slave: split the current transaction
s_split_ready  input  1  level from the slave: parked transaction may resume
split_grant  output  1  to the slave: the resumed owner holds the bus
owner  output  2  0 = none, 1 = master 1, 2 = master 2; selects the bus mux

Behaviour:
- All outputs are registered. Reset is synchronous on rstn=0 and sets:
  - every output to 0;
  - state IDLE, split pending flag 0, split owner 0, last_grant = master 2 (so master 1 wins the first round-robin tie).
- Reset mid-tenure drops grants and clears the pending split on the next edge.
- States:
  - IDLE
  - GNT1
  - GNT2
- IDLE, decision order:
  - (a) If a split is pending and s_split_ready=1: grant the split owner, set split_grant=1, clear that master's mN_split. If that owner's breq=0, the split is abandoned instead: clear pending, issue no grant.
  - (b) Otherwise, grant an eligible requester. Eligible means breq=1 and not parked.
  - Tie-break is by RR_MODE. A single eligible requester always wins.
- Grant latency: a request sampled in IDLE at edge n shows bgrant=1 and owner valid after edge n (one cycle).
- GNTx: the grant is held while mx_breq=1. No preemption.
- Release: mx_breq=0 sampled at edge n deasserts bgrant, owner and split_grant after edge n. The FSM spends at least one cycle in IDLE (turnaround), so the earliest next grant is after edge n+1.
- Split: s_split=1 sampled in GNTx.
  - Record x as split owner, set pending.
  - Drop mx_bgrant, set mx_split=1, go to IDLE.
  - The other master may be granted from the next IDLE decision.
- The parked master's breq is ignored for normal arbitration until it is resumed.
- Resume happens only from IDLE; an ongoing tenure of the other master completes first. While pending, a resumed owner has priority over normal requests.
- s_split_ready=1 with nothing pending is ignored.
- Simultaneous events:
  - s_split and breq drop in the same cycle: split wins, the master is parked.
  - s_split while a split is already pending, or s_split in IDLE: ignored, state unchanged.
- last_grant updates on every grant, including resumes.
- m1_bgrant and m2_bgrant are never both 1. owner always equals the granted master.

Test Plan:
- Reset, then m1_breq=1 at cycle 2 → m1_bgrant=1 and owner=1 from cycle 3; m2_bgrant stays 0.
- RR_MODE=1, both request continuously, each drops breq 4 cycles after its grant → grants alternate 1,2,1,2, with exactly one IDLE cycle between tenures; with RR_MODE=0 and both re-raising immediately, master 1 always wins.
- Master 2 granted, s_split pulse → m2_bgrant=0 and m2_split=1 next cycle; m1_breq=1 → m1 granted after IDLE; s_split_ready=1 during the m1 tenure → no change; m1 releases → m2 regranted with split_grant=1 and m2_split=0.
- Split pending, s_split_ready=1 and m1_breq=1 in the same IDLE cycle → the parked master 2 wins.
- s_split and m1_breq fall in the same cycle → m1_split=1 and pending set; a second s_split during m2's tenure → ignored, m2 keeps its grant.
- rstn=0 for one cycle during a GNT2 tenure with a split pending → all outputs 0 next cycle; pending cleared; first grant after reset goes to master 1 on a tie.
